// File: rtl/dual_input_debouncer.sv
// dual_input_debouncer
//
// Conditions two raw, asynchronous switch/button inputs for the two-input
// gate block. Each channel is synchronised with two flops, then debounced
// by a stability counter: a new synchronised level must be seen on
// STABLE_CYCLES consecutive edges before it is accepted onto the output.
// The two channels are identical and fully independent. There is no
// arbitration between them.
//
// Ports
//   clk_in      : system clock; all state updates on the rising edge
//   rst_n_in    : synchronous, active-low reset
//   a_raw_in    : raw bouncy input A (asynchronous)
//   b_raw_in    : raw bouncy input B (asynchronous)
//   a_out       : debounced level A (registered), feeds gate block a_in
//   b_out       : debounced level B (registered), feeds gate block b_in
//   a_rise_out  : one-cycle pulse after a_out goes 0->1
//   a_fall_out  : one-cycle pulse after a_out goes 1->0
//   b_rise_out  : one-cycle pulse after b_out goes 0->1
//   b_fall_out  : one-cycle pulse after b_out goes 1->0
//
// Parameters
//   STABLE_CYCLES : 2..65535, consecutive cycles a new level must persist
//   CNT_WIDTH     : counter width, 2**CNT_WIDTH must exceed STABLE_CYCLES-1
//
// Latency: if edge 0 is the first edge that samples a new raw level into
// the first sync flop, the output and its pulse update at edge
// STABLE_CYCLES+1.
//
// Per-channel state (signal "state", index 0 = A, 1 = B):
//   IDLE     : synchronised level equals the output, counter held at 0
//   COUNTING : synchronised level differs from the output

module dual_input_debouncer #(
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_WIDTH     = 16
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic a_raw_in,
    input  logic b_raw_in,
    output logic a_out,
    output logic b_out,
    output logic a_rise_out,
    output logic a_fall_out,
    output logic b_rise_out,
    output logic b_fall_out
);

    typedef enum logic {
        IDLE     = 1'b0,
        COUNTING = 1'b1
    } state_t;

    // Terminal count: the edge that sees the STABLE_CYCLES-th consecutive
    // differing sample is the one that finds cnt at this value.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    // Index 0 is channel A, index 1 is channel B.
    logic [1:0]           raw;
    logic [1:0]           s1;
    logic [1:0]           s2;
    logic [1:0]           level;
    logic [1:0]           rise;
    logic [1:0]           fall;
    logic [CNT_WIDTH-1:0] cnt [2];

    logic [1:0]           level_next;
    logic [1:0]           rise_next;
    logic [1:0]           fall_next;
    logic [CNT_WIDTH-1:0] cnt_next [2];
    state_t               state [2];

    assign raw = {b_raw_in, a_raw_in};

    // State register: sync flops, counters, levels and pulse flops.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            s1    <= '0;
            s2    <= '0;
            level <= '0;
            rise  <= '0;
            fall  <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1    <= raw;
            s2    <= s1;
            level <= level_next;
            rise  <= rise_next;
            fall  <= fall_next;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // Next-state logic. Only s2 (the fully synchronised sample) is used.
    // A single sample that matches the output returns the channel to IDLE
    // and restarts the count, which is what rejects glitches.
    always_comb begin
        level_next = level;
        rise_next  = '0;
        fall_next  = '0;
        for (int i = 0; i < 2; i++) begin
            cnt_next[i] = cnt[i];
            state[i]    = (s2[i] != level[i]) ? COUNTING : IDLE;

            case (state[i])
                IDLE: begin
                    cnt_next[i] = '0;
                end
                COUNTING: begin
                    if (cnt[i] == CNT_LAST) begin
                        level_next[i] = s2[i];
                        cnt_next[i]   = '0;
                        rise_next[i]  = s2[i];
                        fall_next[i]  = ~s2[i];
                    end else begin
                        cnt_next[i] = cnt[i] + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    cnt_next[i] = '0;
                end
            endcase
        end
    end

    assign a_out      = level[0];
    assign b_out      = level[1];
    assign a_rise_out = rise[0];
    assign a_fall_out = fall[0];
    assign b_rise_out = rise[1];
    assign b_fall_out = fall[1];

endmodule
